muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer that owns HI/LO.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are no-ops.

module muldiv_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        FREEZE,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic [31:0] OpA,
    input  logic [31:0] OpB,
    input  logic        hilo_rd,
    input  logic        hilo_wr,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        md_busy,
    output logic        md_stall,
    output logic        md_done
);

`ifdef MULDIV_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] m_q, m_d;
    logic        sq_q, sq_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        op_sgn, neg_a, neg_b;
    logic        start_vld, accept;
    logic [31:0] abs_a, abs_b;
    logic [32:0] sum;
    logic [63:0] mul_nxt, prod;
    logic        ext_fin;
    logic [63:0] ext_ld, ext_nxt, ext_res;

    // Operand conditioning, multiply step and handshake outputs
    always_comb begin
        op_sgn    = ~md_op[0];
        neg_a     = op_sgn & OpA[31];
        neg_b     = op_sgn & OpB[31];
        abs_a     = neg_a ? (~OpA + 32'd1) : OpA;
        abs_b     = neg_b ? (~OpB + 32'd1) : OpB;
        start_vld = md_start & (~md_op[1] | DIV_EN);
        accept    = (state_q == IDLE) & start_vld & ~FREEZE;
        md_busy   = (state_q != IDLE);
        md_stall  = md_busy & (start_vld | hilo_rd | hilo_wr);
        md_done   = (state_q == FIN);
        sum       = {1'b0, acc_q[63:32]} + {1'b0, m_q};
        mul_nxt   = acc_q[0] ? {sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        prod      = sq_q ? (~acc_q + 64'd1) : acc_q;
    end

`ifdef MULDIV_DIV_EN
    logic        div_q, div_d;
    logic        sr_q, sr_d;
    logic        dz_q, dz_d;
    logic [32:0] diff;
    logic [63:0] div_nxt;
    logic [31:0] quo, rem;

    // Restoring divide step, result selection and divide flag updates
    always_comb begin
        div_d   = div_q;
        sr_d    = sr_q;
        dz_d    = dz_q;
        diff    = acc_q[63:31] - {1'b0, m_q};
        div_nxt = diff[32] ? {acc_q[62:0], 1'b0}
                           : {diff[31:0], acc_q[30:0], 1'b1};
        quo     = sq_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem     = sr_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
        ext_fin = md_op[1] & (OpB == 32'd0);
        if (!md_op[1])
            ext_ld = {32'd0, abs_b};
        else if (ext_fin)
            ext_ld = {OpA, 32'hFFFF_FFFF};
        else
            ext_ld = {32'd0, abs_a};
        ext_nxt = div_q ? div_nxt : mul_nxt;
        if (dz_q)
            ext_res = acc_q;
        else if (div_q)
            ext_res = {rem, quo};
        else
            ext_res = prod;
        if (accept) begin
            div_d = md_op[1];
            sr_d  = neg_a;
            dz_d  = ext_fin;
        end
    end

    // Divide flag registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            div_q <= 1'b0;
            sr_q  <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            sr_q  <= sr_d;
            dz_q  <= dz_d;
        end
    end
`else
    // Multiply-only datapath selection
    always_comb begin
        ext_fin = 1'b0;
        ext_ld  = {32'd0, abs_b};
        ext_nxt = mul_nxt;
        ext_res = prod;
    end
`endif

    // Next-state, iteration and HI/LO update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        sq_d    = sq_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = ext_fin ? FIN : RUN;
                    cnt_d   = ext_fin ? 5'd0 : 5'd31;
                    acc_d   = ext_ld;
                    m_d     = md_op[1] ? abs_b : abs_a;
                    sq_d    = neg_a ^ neg_b;
                end else if (hilo_wr && !FREEZE) begin
                    if (hilo_sel)
                        hi_d = hilo_wdata;
                    else
                        lo_d = hilo_wdata;
                end
            end
            RUN: begin
                acc_d = ext_nxt;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = FIN;
                    cnt_d   = 5'd0;
                end
            end
            FIN: begin
                hi_d    = ext_res[63:32];
                lo_d    = ext_res[31:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            m_q     <= 32'd0;
            sq_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            sq_q    <= sq_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl.
// Divider cases run when MULDIV_DIV_EN is defined, no-op cases otherwise.

module tb_muldiv_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        FREEZE = 1'b0;
    logic        md_start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic [31:0] OpA = 32'd0;
    logic [31:0] OpB = 32'd0;
    logic        hilo_rd = 1'b0;
    logic        hilo_wr = 1'b0;
    logic        hilo_sel = 1'b0;
    logic [31:0] hilo_wdata = 32'd0;
    logic [31:0] HI, LO;
    logic        md_busy, md_stall, md_done;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_ctrl dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE),
        .md_start(md_start), .md_op(md_op), .OpA(OpA), .OpB(OpB),
        .hilo_rd(hilo_rd), .hilo_wr(hilo_wr), .hilo_sel(hilo_sel),
        .hilo_wdata(hilo_wdata), .HI(HI), .LO(LO),
        .md_busy(md_busy), .md_stall(md_stall), .md_done(md_done)
    );

    always #5 CLK = ~CLK;

    // One-cycle request; returns at the negedge right after the accept edge
    task automatic issue(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge CLK);
        md_start = 1'b1; md_op = op; OpA = a; OpB = b;
        @(negedge CLK);
        md_start = 1'b0;
    endtask

    // Bounded wait for the unit to go idle, counting cycles and done pulses
    task automatic wait_idle(output int cyc, output int dones);
        cyc = 0; dones = 0;
        while (md_busy && cyc < 60) begin
            if (md_done) dones++;
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic hilo_write(input logic sel, input logic [31:0] d);
        @(negedge CLK);
        hilo_wr = 1'b1; hilo_sel = sel; hilo_wdata = d;
        @(negedge CLK);
        hilo_wr = 1'b0;
    endtask

    task automatic test_reset;
        #2 RESET = 1'b0;
        #1;
        n_cmp++; if (HI !== 32'd0) begin n_bad++; $display("FAIL rst_hi got %h want 0", HI); end
        n_cmp++; if (LO !== 32'd0) begin n_bad++; $display("FAIL rst_lo got %h want 0", LO); end
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", md_busy); end
        n_cmp++; if (md_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", md_done); end
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_mult;
        int cyc, dn;
        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(cyc, dn);
        n_cmp++; if (cyc + 1 !== 34) begin n_bad++; $display("FAIL mult_lat got %0d want 34", cyc + 1); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL mult_done got %0d want 1", dn); end
        n_cmp++; if (HI !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi got %h want ffffffff", HI); end
        n_cmp++; if (LO !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL mult_lo got %h want fffffffe", LO); end
        issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle(cyc, dn);
        n_cmp++; if (HI !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_hi got %h want 00000001", HI); end
        n_cmp++; if (LO !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_lo got %h want fffffffe", LO); end
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_idle(cyc, dn);
        n_cmp++; if (HI !== 32'h4000_0000) begin n_bad++; $display("FAIL mult_min_hi got %h want 40000000", HI); end
        n_cmp++; if (LO !== 32'h0000_0000) begin n_bad++; $display("FAIL mult_min_lo got %h want 0", LO); end
        issue(2'b00, 32'hFFFF_FFF9, 32'h0000_0003);
        wait_idle(cyc, dn);
        n_cmp++; if (HI !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_neg_hi got %h want ffffffff", HI); end
        n_cmp++; if (LO !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_neg_lo got %h want ffffffeb", LO); end
    endtask

    task automatic test_hilo_wr;
        int cyc, dn;
        hilo_write(1'b1, 32'hCAFE_F00D);
        n_cmp++; if (HI !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mthi got %h want cafef00d", HI); end
        hilo_write(1'b0, 32'h0BAD_BEEF);
        n_cmp++; if (LO !== 32'h0BAD_BEEF) begin n_bad++; $display("FAIL mtlo got %h want 0badbeef", LO); end
        n_cmp++; if (HI !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL mtlo_hi got %h want cafef00d", HI); end
        FREEZE = 1'b1;
        hilo_write(1'b0, 32'h1111_1111);
        n_cmp++; if (LO !== 32'h0BAD_BEEF) begin n_bad++; $display("FAIL frz_wr got %h want 0badbeef", LO); end
        issue(2'b00, 32'd3, 32'd5);
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL frz_start got %b want 0", md_busy); end
        FREEZE = 1'b0;
        @(negedge CLK);
        md_start = 1'b1; md_op = 2'b00; OpA = 32'd3; OpB = 32'd5;
        hilo_wr = 1'b1; hilo_sel = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        md_start = 1'b0; hilo_wr = 1'b0;
        n_cmp++; if (md_busy !== 1'b1) begin n_bad++; $display("FAIL both_acc got %b want 1", md_busy); end
        n_cmp++; if (HI !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL both_hi got %h want cafef00d", HI); end
        FREEZE = 1'b1;
        wait_idle(cyc, dn);
        FREEZE = 1'b0;
        n_cmp++; if (LO !== 32'h0000_000F) begin n_bad++; $display("FAIL frz_run_lo got %h want 0000000f", LO); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div;
        int cyc, dn;
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle(cyc, dn);
        n_cmp++; if (cyc + 1 !== 34) begin n_bad++; $display("FAIL div_lat got %0d want 34", cyc + 1); end
        n_cmp++; if (LO !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo got %h want fffffffd", LO); end
        n_cmp++; if (HI !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi got %h want ffffffff", HI); end
        issue(2'b11, 32'd100, 32'd7);
        wait_idle(cyc, dn);
        n_cmp++; if (LO !== 32'h0000_000E) begin n_bad++; $display("FAIL divu_lo got %h want 0000000e", LO); end
        n_cmp++; if (HI !== 32'h0000_0002) begin n_bad++; $display("FAIL divu_hi got %h want 00000002", HI); end
        issue(2'b10, 32'h1234_5678, 32'h0000_0000);
        wait_idle(cyc, dn);
        n_cmp++; if (cyc + 1 !== 2) begin n_bad++; $display("FAIL dz_lat got %0d want 2", cyc + 1); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL dz_done got %0d want 1", dn); end
        n_cmp++; if (HI !== 32'h1234_5678) begin n_bad++; $display("FAIL dz_hi got %h want 12345678", HI); end
        n_cmp++; if (LO !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL dz_lo got %h want ffffffff", LO); end
    endtask
`else
    task automatic test_div_noop;
        int cyc, dn;
        hilo_write(1'b1, 32'h1357_9BDF);
        hilo_write(1'b0, 32'h2468_ACE0);
        issue(2'b10, 32'd100, 32'd7);
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL noop_busy got %b want 0", md_busy); end
        dn = 0;
        for (int i = 0; i < 36; i++) begin
            if (md_done) dn++;
            @(negedge CLK);
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL noop_done got %0d want 0", dn); end
        n_cmp++; if (HI !== 32'h1357_9BDF) begin n_bad++; $display("FAIL noop_hi got %h want 13579bdf", HI); end
        n_cmp++; if (LO !== 32'h2468_ACE0) begin n_bad++; $display("FAIL noop_lo got %h want 2468ace0", LO); end
        issue(2'b00, 32'd2, 32'd2);
        md_start = 1'b1; md_op = 2'b11;
        #1;
        n_cmp++; if (md_stall !== 1'b0) begin n_bad++; $display("FAIL noop_stall got %b want 0", md_stall); end
        md_start = 1'b0;
        wait_idle(cyc, dn);
        n_cmp++; if (LO !== 32'h0000_0004) begin n_bad++; $display("FAIL noop_mul_lo got %h want 00000004", LO); end
    endtask
`endif

    task automatic test_stall;
        int cnt;
        issue(2'b00, 32'd6, 32'd7);
        #1;
        n_cmp++; if (md_stall !== 1'b0) begin n_bad++; $display("FAIL stall_idle got %b want 0", md_stall); end
        hilo_rd = 1'b1;
        #1;
        cnt = 0;
        while (md_stall && cnt < 60) begin
            @(negedge CLK);
            #1;
            cnt++;
        end
        n_cmp++; if (cnt !== 33) begin n_bad++; $display("FAIL stall_len got %0d want 33", cnt); end
        n_cmp++; if (LO !== 32'h0000_002A) begin n_bad++; $display("FAIL stall_lo got %h want 0000002a", LO); end
        hilo_rd = 1'b0;
    endtask

    task automatic test_back_to_back;
        int cyc, dn;
        @(negedge CLK);
        md_start = 1'b1; md_op = 2'b00; OpA = 32'd2; OpB = 32'd3;
        @(negedge CLK);
        md_op = 2'b01; OpA = 32'h0001_0000; OpB = 32'h0001_0000;
        #1;
        n_cmp++; if (md_stall !== 1'b1) begin n_bad++; $display("FAIL b2b_stall got %b want 1", md_stall); end
        wait_idle(cyc, dn);
        n_cmp++; if (LO !== 32'h0000_0006) begin n_bad++; $display("FAIL b2b_first got %h want 00000006", LO); end
        @(negedge CLK);
        md_start = 1'b0;
        wait_idle(cyc, dn);
        n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL b2b_lat got %0d want 33", cyc); end
        n_cmp++; if (HI !== 32'h0000_0001) begin n_bad++; $display("FAIL b2b_hi got %h want 00000001", HI); end
        n_cmp++; if (LO !== 32'h0000_0000) begin n_bad++; $display("FAIL b2b_lo got %h want 0", LO); end
    endtask

    task automatic test_reset_mid;
        int cyc, dn;
        issue(2'b00, 32'd7, 32'd9);
        repeat (10) @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy got %b want 0", md_busy); end
        n_cmp++; if (HI !== 32'd0) begin n_bad++; $display("FAIL mrst_hi got %h want 0", HI); end
        n_cmp++; if (LO !== 32'd0) begin n_bad++; $display("FAIL mrst_lo got %h want 0", LO); end
        @(negedge CLK);
        RESET = 1'b1;
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            if (md_done) dn++;
            @(negedge CLK);
        end
        n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL mrst_done got %0d want 0", dn); end
        issue(2'b00, 32'd3, 32'd5);
        wait_idle(cyc, dn);
        n_cmp++; if (LO !== 32'h0000_000F) begin n_bad++; $display("FAIL mrst_lo2 got %h want 0000000f", LO); end
        n_cmp++; if (HI !== 32'h0000_0000) begin n_bad++; $display("FAIL mrst_hi2 got %h want 0", HI); end
    endtask

    initial begin
        test_reset;
        test_mult;
        test_hilo_wr;
`ifdef MULDIV_DIV_EN
        test_div;
`else
        test_div_noop;
`endif
        test_stall;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
